// File: rtl/cpu_instruction_cache.sv
// Direct-mapped instruction cache for the fetch port. It holds one word per entry,
// tagged with the full word address. On a miss it fetches the aligned 4-word block
// from the memory arbiter. After reset, or on a flush pulse, it sweeps every entry invalid.
module cpu_instruction_cache #(
    parameter int CACHE_DEPTH_BITS = 8
) (
    input  logic        CLK,
    input  logic        RSTb,
    input  logic [14:0] cache_request_address,
    output logic [31:0] cache_line,
    output logic        cache_miss,
    input  logic        cache_flush,
    output logic        mem_request,
    output logic [14:0] mem_address,
    input  logic        mem_valid,
    input  logic [15:0] mem_data,
    output logic        busy
);

    localparam int DEPTH = 1 << CACHE_DEPTH_BITS;
    localparam logic [CACHE_DEPTH_BITS-1:0] CNT_ZERO = {CACHE_DEPTH_BITS{1'b0}};
    localparam logic [CACHE_DEPTH_BITS-1:0] CNT_MAX  = {CACHE_DEPTH_BITS{1'b1}};
    localparam logic [CACHE_DEPTH_BITS-1:0] CNT_ONE  = {{(CACHE_DEPTH_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        st_flush = 2'd0,
        st_idle  = 2'd1,
        st_fill  = 2'd2
    } state_t;

    // Each entry is packed as {stored address[14:0], valid, instruction[15:0]}.
    logic [31:0]                 ram_r [DEPTH];
    logic [31:0]                 line_r;
    logic [14:0]                 addr_r;
    state_t                      state_r;
    state_t                      state_s;
    logic [CACHE_DEPTH_BITS-1:0] flush_cnt_r;
    logic [CACHE_DEPTH_BITS-1:0] flush_cnt_s;
    logic [14:0]                 fill_base_r;
    logic [14:0]                 fill_base_s;
    logic [1:0]                  beat_r;
    logic [1:0]                  beat_s;
    logic                        flush_pend_r;
    logic                        flush_pend_s;
    logic                        mem_request_r;
    logic                        busy_r;
    logic                        wr_en_s;
    logic [CACHE_DEPTH_BITS-1:0] wr_idx_s;
    logic [31:0]                 wr_data_s;
    logic [14:0]                 wr_addr_s;
    logic [CACHE_DEPTH_BITS-1:0] rd_idx_s;
    logic                        cache_miss_s;

    // The beat address stays inside the aligned block, so the low two bits never carry.
    assign wr_addr_s = {fill_base_r[14:2], beat_r};
    assign rd_idx_s  = cache_request_address[CACHE_DEPTH_BITS-1:0];

    // The sweep forces a miss, because entries are invalid or stale while it runs.
    assign cache_miss_s = (~line_r[16]) | (line_r[31:17] != addr_r) | (state_r == st_flush);

    assign cache_line  = line_r;
    assign cache_miss  = cache_miss_s;
    assign mem_request = mem_request_r;
    assign mem_address = fill_base_r;
    assign busy        = busy_r;

    // Storage write port. It has no reset, because the sweep is what clears the valid bits.
    always_ff @(posedge CLK) begin
        if (wr_en_s) begin
            ram_r[wr_idx_s] <= wr_data_s;
        end
    end

    // Synchronous lookup. A write to the same index in this cycle is not visible until the next read.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            line_r <= 32'd0;
            addr_r <= 15'd0;
        end else begin
            line_r <= ram_r[rd_idx_s];
            addr_r <= cache_request_address;
        end
    end

    // Next-state logic for the sweep and refill controller, plus the storage write selection.
    always_comb begin
        state_s      = state_r;
        flush_cnt_s  = flush_cnt_r;
        fill_base_s  = fill_base_r;
        beat_s       = beat_r;
        flush_pend_s = flush_pend_r;
        wr_en_s      = 1'b0;
        wr_idx_s     = CNT_ZERO;
        wr_data_s    = 32'd0;
        case (state_r)
            st_flush: begin
                wr_en_s      = 1'b1;
                wr_idx_s     = flush_cnt_r;
                wr_data_s    = 32'd0;
                flush_pend_s = 1'b0;
                if (cache_flush) begin
                    flush_cnt_s = CNT_ZERO;
                end else if (flush_cnt_r == CNT_MAX) begin
                    flush_cnt_s = CNT_ZERO;
                    state_s     = st_idle;
                end else begin
                    flush_cnt_s = flush_cnt_r + CNT_ONE;
                end
            end
            st_idle: begin
                if (cache_flush) begin
                    flush_cnt_s = CNT_ZERO;
                    state_s     = st_flush;
                end else if (cache_miss_s) begin
                    fill_base_s = {addr_r[14:2], 2'b00};
                    beat_s      = 2'd0;
                    state_s     = st_fill;
                end else begin
                    state_s = st_idle;
                end
            end
            st_fill: begin
                // A flush pulse during a burst is remembered and acted on once the burst completes.
                if (cache_flush) begin
                    flush_pend_s = 1'b1;
                end else begin
                    flush_pend_s = flush_pend_r;
                end
                if (mem_valid) begin
                    wr_en_s   = 1'b1;
                    wr_idx_s  = wr_addr_s[CACHE_DEPTH_BITS-1:0];
                    wr_data_s = {wr_addr_s, 1'b1, mem_data};
                    beat_s    = beat_r + 2'd1;
                    if (beat_r == 2'd3) begin
                        flush_cnt_s = CNT_ZERO;
                        if (flush_pend_r || cache_flush) begin
                            state_s = st_flush;
                        end else begin
                            state_s = st_idle;
                        end
                    end else begin
                        state_s = st_fill;
                    end
                end else begin
                    state_s = st_fill;
                end
            end
            default: begin
                flush_cnt_s = CNT_ZERO;
                state_s     = st_flush;
            end
        endcase
    end

    // Controller state and registered handshake outputs. Reset aborts any burst that is in flight.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_r       <= st_flush;
            flush_cnt_r   <= CNT_ZERO;
            fill_base_r   <= 15'd0;
            beat_r        <= 2'd0;
            flush_pend_r  <= 1'b0;
            mem_request_r <= 1'b0;
            busy_r        <= 1'b1;
        end else begin
            state_r       <= state_s;
            flush_cnt_r   <= flush_cnt_s;
            fill_base_r   <= fill_base_s;
            beat_r        <= beat_s;
            flush_pend_r  <= flush_pend_s;
            mem_request_r <= (state_s == st_fill);
            busy_r        <= (state_s != st_idle);
        end
    end

endmodule

// File: tb/tb_cpu_instruction_cache.sv
// Directed bench for cpu_instruction_cache with a 16-entry cache.
// The memory side is driven from tasks, and expected cache lines are hand-computed constants.
module tb_cpu_instruction_cache;

    logic        CLK;
    logic        RSTb;
    logic [14:0] cache_request_address;
    logic [31:0] cache_line;
    logic        cache_miss;
    logic        cache_flush;
    logic        mem_request;
    logic [14:0] mem_address;
    logic        mem_valid;
    logic [15:0] mem_data;
    logic        busy;

    int vec_count = 0;
    int miscompare_count = 0;

    cpu_instruction_cache #(.CACHE_DEPTH_BITS(4)) dut (
        .CLK                   (CLK),
        .RSTb                  (RSTb),
        .cache_request_address (cache_request_address),
        .cache_line            (cache_line),
        .cache_miss            (cache_miss),
        .cache_flush           (cache_flush),
        .mem_request           (mem_request),
        .mem_address           (mem_address),
        .mem_valid             (mem_valid),
        .mem_data              (mem_data),
        .busy                  (busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Memory contents: word at address a is 0xA000 + a - 4, so 0x0004..0x0007 hold 0xA000..0xA003.
    function automatic logic [15:0] mem_word(input logic [14:0] a);
        return 16'hA000 + {1'b0, a} - 16'h0004;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_count++;
        if (obs !== exp) begin
            miscompare_count++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mem_request === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        if (!ok) check_val("req_timeout", 32'(mem_request), 32'd1);
    endtask

    // Returns four beats of the burst at mem_address. It can insert a gap cycle before beat gap_at,
    // pulse cache_flush with beat flush_at, or assert reset after beat rst_at.
    task automatic deliver(input int gap_at, input int flush_at, input int rst_at);
        logic [14:0] base;
        base = mem_address;
        for (int b = 0; b < 4; b++) begin
            if (b == gap_at) begin
                mem_valid = 1'b0;
                @(negedge CLK);
            end
            mem_valid   = 1'b1;
            mem_data    = mem_word(base + 15'(b));
            cache_flush = (b == flush_at);
            @(negedge CLK);
            cache_flush = 1'b0;
            if (b == rst_at) begin
                mem_valid = 1'b0;
                RSTb = 1'b0;
                #1;
                check_val("rst_req_drop", 32'(mem_request), 32'd0);
                return;
            end
        end
        mem_valid = 1'b0;
    endtask

    task automatic fill(input string tag, input logic [14:0] exp_base,
                        input int gap_at, input int flush_at, input int rst_at);
        bit ok;
        wait_req(ok);
        if (ok) begin
            check_val({tag, "_addr"}, 32'(mem_address), 32'(exp_base));
            deliver(gap_at, flush_at, rst_at);
            if (rst_at < 0) check_val({tag, "_req_drop"}, 32'(mem_request), 32'd0);
        end
    endtask

    // Serves any follow-up refill until the cache is idle and hitting.
    task automatic settle(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (mem_request === 1'b1) begin
                deliver(-1, -1, -1);
            end else if (busy === 1'b0 && cache_miss === 1'b0) begin
                done = 1'b1;
            end else begin
                @(negedge CLK);
            end
        end
        if (!done) check_val({tag, "_settle"}, {30'd0, busy, cache_miss}, 32'd0);
    endtask

    // The sweep lasts 16 cycles with cache_miss and busy high and no memory request. The addressed entry is then invalid.
    task automatic check_sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            check_val({tag, "_miss"}, 32'(cache_miss), 32'd1);
            check_val({tag, "_busy"}, 32'(busy), 32'd1);
            check_val({tag, "_req"}, 32'(mem_request), 32'd0);
            @(negedge CLK);
        end
        check_val({tag, "_busy_end"}, 32'(busy), 32'd0);
        check_val({tag, "_miss_end"}, 32'(cache_miss), 32'd1);
        check_val({tag, "_valid_end"}, 32'(cache_line[16]), 32'd0);
    endtask

    task automatic hit(input string tag, input logic [14:0] a, input logic [31:0] exp_line);
        cache_request_address = a;
        @(negedge CLK);
        check_val({tag, "_line"}, cache_line, exp_line);
        check_val({tag, "_miss"}, 32'(cache_miss), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        RSTb = 1'b0;
        cache_request_address = 15'h0005;
        cache_flush = 1'b0;
        mem_valid = 1'b0;
        mem_data = 16'h0000;
        repeat (3) @(negedge CLK);
        check_val("rst_line", cache_line, 32'h0000_0000);
        check_val("rst_miss", 32'(cache_miss), 32'd1);
        check_val("rst_req", 32'(mem_request), 32'd0);
        check_val("rst_maddr", 32'(mem_address), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd1);
        RSTb = 1'b1;
        check_sweep("boot");

        // Cold miss at 0x0005 with one gap cycle in the burst.
        fill("cold", 15'h0004, 2, -1, -1);
        settle("cold");
        hit("cold4", 15'h0004, 32'h0009_A000);
        hit("cold5", 15'h0005, 32'h000B_A001);
        hit("cold6", 15'h0006, 32'h000D_A002);
        hit("cold7", 15'h0007, 32'h000F_A003);

        // 0x0015 shares index 5 with 0x0005.
        cache_request_address = 15'h0015;
        @(negedge CLK);
        check_val("alias_miss", 32'(cache_miss), 32'd1);
        check_val("alias_old_line", cache_line, 32'h000B_A001);
        fill("alias", 15'h0014, -1, -1, -1);
        settle("alias");
        hit("alias15", 15'h0015, 32'h002B_A011);
        cache_request_address = 15'h0005;
        @(negedge CLK);
        check_val("alias_back_miss", 32'(cache_miss), 32'd1);
        fill("alias_back", 15'h0004, -1, -1, -1);
        settle("alias_back");

        // Redirect during a fill: the burst completes, then the new address is fetched.
        cache_request_address = 15'h0009;
        @(negedge CLK);
        wait_req(ok);
        cache_request_address = 15'h0020;
        fill("redir", 15'h0008, -1, -1, -1);
        fill("redir_next", 15'h0020, -1, -1, -1);
        settle("redir");
        hit("redir20", 15'h0020, 32'h0041_A01C);
        hit("redir0b", 15'h000B, 32'h0017_A007);

        // Flush pulsed with beat 2: the burst finishes, then a full sweep runs.
        cache_request_address = 15'h0038;
        fill("fl", 15'h0038, -1, 1, -1);
        cache_request_address = 15'h0008;
        check_sweep("fl_sweep");
        fill("fl_refill", 15'h0008, -1, -1, -1);
        settle("fl");

        // Reset after beat 1 aborts the burst, and the entry from beat 1 is swept.
        cache_request_address = 15'h0011;
        fill("rst", 15'h0010, -1, -1, 0);
        cache_request_address = 15'h0010;
        @(negedge CLK);
        RSTb = 1'b1;
        check_sweep("rst_sweep");
        fill("rst_refill", 15'h0010, -1, -1, -1);
        settle("rst");
        hit("rst10", 15'h0010, 32'h0021_A00C);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
        $finish;
    end

endmodule
